// File: rtl/pa_mode1_out_ctrl.sv
// Port A output latch and mode-1 OBF#/ACK#/INTR handshake sequencer (8255A style).
// Optional ack timeout built when PA_ACK_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | latch empty or already taken, obf_n=1
// FULL  | new data on pa_out, obf_n=0, waiting for ack fall
// ACKED | peripheral strobed data, obf_n=1, waiting for ack rise
module pa_mode1_out_ctrl #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mode1,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          inte_set,
  input  logic          inte_clr,
  input  logic          ack_n,
  output logic [DW-1:0] pa_out,
  output logic          obf_n,
  output logic          intr,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    ACKED = 2'd2
  } state_t;

  state_t                 state;
  logic                   inte;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_d;
  logic                   ack_fall;
  logic                   ack_rise;
  logic                   tmo_hit;

  // synchronizer idles high so a released reset never looks like an ack edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync <= '1;
      ack_d    <= 1'b1;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_n};
      ack_d    <= ack_sync[SYNC_STAGES-1];
    end
  end

  assign ack_fall = ack_d & ~ack_sync[SYNC_STAGES-1];
  assign ack_rise = ~ack_d & ack_sync[SYNC_STAGES-1];

`ifdef PA_ACK_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = (state == FULL) && (tmo_cnt == TC_LAST);

  // a write re-enters FULL, so it restarts the wait
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (!mode1 || wr_en || state != FULL) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= mode1 && !wr_en && !ack_fall && tmo_hit;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      obf_n  <= 1'b1;
      intr   <= 1'b0;
      inte   <= 1'b0;
      pa_out <= '0;
    end else begin
      if (inte_clr) begin
        inte <= 1'b0;
      end else if (inte_set) begin
        inte <= 1'b1;
      end

      if (wr_en) begin
        pa_out <= din;
      end

      if (!mode1) begin
        state <= IDLE;
        obf_n <= 1'b1;
        intr  <= 1'b0;
      end else if (wr_en) begin
        state <= FULL;
        obf_n <= 1'b0;
        intr  <= 1'b0;
      end else begin
        case (state)
          FULL: begin
            if (ack_fall) begin
              state <= ACKED;
              obf_n <= 1'b1;
            end else if (tmo_hit) begin
              state <= IDLE;
              obf_n <= 1'b1;
              intr  <= inte;
            end
          end
          ACKED: begin
            if (ack_rise) begin
              state <= IDLE;
              intr  <= inte;
            end
          end
          IDLE: ;
          default: begin
            state <= IDLE;
            obf_n <= 1'b1;
          end
        endcase
      end

      // clearing INTE also withdraws a pending request
      if (inte_clr) begin
        intr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pa_mode1_out_ctrl.sv
// Bench for pa_mode1_out_ctrl: directed handshake scenarios plus random traffic
// against a cycle reference model of the port A handshake.
module tb_pa_mode1_out_ctrl;

  localparam int DW = 8;
  localparam int S  = 2;
`ifdef PA_ACK_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk;
  logic          reset_n;
  logic          mode1;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          inte_set;
  logic          inte_clr;
  logic          ack_n;
  logic [DW-1:0] pa_out;
  logic          obf_n;
  logic          intr;
  logic          timeout_err;

  int n_chk = 0;
  int n_err = 0;

  pa_mode1_out_ctrl #(.DW(DW), .SYNC_STAGES(S), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .mode1(mode1), .wr_en(wr_en), .din(din),
    .inte_set(inte_set), .inte_clr(inte_clr), .ack_n(ack_n),
    .pa_out(pa_out), .obf_n(obf_n), .intr(intr), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: handshake phase 0=empty, 1=waiting for ack, 2=waiting for release
  logic [DW-1:0] m_pa;
  int            m_phase;
  logic          m_intr;
  logic          m_inte;
  logic          m_terr;
  int            m_cnt;
  logic          hist [0:S];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pa = '0; m_phase = 0; m_intr = 1'b0; m_inte = 1'b0; m_terr = 1'b0; m_cnt = 0;
    for (int i = 0; i <= S; i++) hist[i] = 1'b1;
  endtask

  task automatic model_edge();
    logic fall, rise, tmo, new_intr;
    int   new_phase, new_cnt;
    if (!reset_n) begin
      model_reset();
      return;
    end
    // pin value seen by the FSM lags the pin by S edges, previous one by S+1
    fall = hist[S] && !hist[S-1];
    rise = !hist[S] && hist[S-1];
`ifdef PA_ACK_TIMEOUT_EN
    tmo = (m_phase == 1) && (m_cnt == TO - 1);
`else
    tmo = 1'b0;
`endif
    new_phase = m_phase;
    new_intr  = m_intr;
    m_terr    = 1'b0;
    if (!mode1) begin
      new_phase = 0; new_intr = 1'b0;
    end else if (wr_en) begin
      new_phase = 1; new_intr = 1'b0;
    end else if (m_phase == 1 && fall) begin
      new_phase = 2;
    end else if (m_phase == 1 && tmo) begin
      new_phase = 0; new_intr = m_inte; m_terr = 1'b1;
    end else if (m_phase == 2 && rise) begin
      new_phase = 0; new_intr = m_inte;
    end
    if (inte_clr) new_intr = 1'b0;
    new_cnt = (!mode1 || wr_en || m_phase != 1) ? 0 : m_cnt + 1;
    if (wr_en) m_pa = din;
    if (inte_clr) m_inte = 1'b0;
    else if (inte_set) m_inte = 1'b1;
    m_phase = new_phase;
    m_intr  = new_intr;
    m_cnt   = new_cnt;
    for (int i = S; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ack_n;
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("pa_out", pa_out, m_pa);
    check("obf_n", obf_n, (m_phase == 1) ? 1'b0 : 1'b1);
    check("intr", intr, m_intr);
    check("timeout_err", timeout_err, m_terr);
  endtask

  task automatic write(input logic [DW-1:0] d);
    wr_en = 1'b1; din = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_set();
    inte_set = 1'b1; cyc(); inte_set = 1'b0;
  endtask

  task automatic pulse_clr();
    inte_clr = 1'b1; cyc(); inte_clr = 1'b0;
  endtask

  task automatic handshake(input int lo, input int hi);
    ack_n = 1'b0;
    repeat (lo) cyc();
    ack_n = 1'b1;
    repeat (hi) cyc();
  endtask

  int n;

  initial begin
    reset_n = 1'b0; mode1 = 1'b0; wr_en = 1'b0; din = '0;
    inte_set = 1'b0; inte_clr = 1'b0; ack_n = 1'b0;
    model_reset();
    @(negedge clk);

    // writes during reset must not reach the latch
    for (int i = 0; i < 4; i++) begin
      wr_en = i[0]; din = DW'($urandom);
      cyc();
    end
    wr_en = 1'b0;
    check("rst_pa", pa_out, 0);
    check("rst_obf", obf_n, 1);
    reset_n = 1'b1;
    repeat (3) cyc();
    ack_n = 1'b1;
    repeat (3) cyc();

    // basic mode-1 handshake with latency measurement
    mode1 = 1'b1;
    pulse_set();
    write(8'hA5);
    check("wr_obf_low", obf_n, 0);
    ack_n = 1'b0;
    n = 0;
    while (obf_n !== 1'b1 && n < 10) begin cyc(); n++; end
    check("ack_fall_lat", n, S + 1);
    cyc();
    ack_n = 1'b1;
    n = 0;
    while (intr !== 1'b1 && n < 10) begin cyc(); n++; end
    check("ack_rise_lat", n, S + 1);

    // write clears intr; with inte cleared handshake raises nothing
    write(8'h3C);
    check("wr_clr_intr", intr, 0);
    pulse_clr();
    handshake(4, 5);
    check("no_inte_intr", intr, 0);

    // overwrite while full, then write on the ack-rise edge
    pulse_set();
    write(8'h11);
    write(8'h22);
    check("overwrite_pa", pa_out, 8'h22);
    ack_n = 1'b0;
    repeat (4) cyc();
    ack_n = 1'b1;
    cyc(); cyc();
    wr_en = 1'b1; din = 8'h77;
    cyc();
    wr_en = 1'b0;
    check("wr_on_rise_obf", obf_n, 0);
    check("wr_on_rise_intr", intr, 0);
    handshake(4, 5);

    // mode 0: plain latch
    mode1 = 1'b0;
    write(8'h5A);
    handshake(4, 5);
    check("m0_pa", pa_out, 8'h5A);
    mode1 = 1'b1;
    write(8'hC3);
    mode1 = 1'b0;
    cyc();
    check("m0_drop_obf", obf_n, 1);
    check("m0_keep_pa", pa_out, 8'hC3);
    mode1 = 1'b1;

    // async reset mid-handshake
    write(8'h99);
    reset_n = 1'b0;
    #1;
    check("async_rst_pa", pa_out, 0);
    check("async_rst_obf", obf_n, 1);
    model_reset();
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();

`ifdef PA_ACK_TIMEOUT_EN
    write(8'h44);
    n = 0;
    while (timeout_err !== 1'b1 && n < 20) begin cyc(); n++; end
    check("tmo_lat", n, TO);
    cyc();
    write(8'h45);
    repeat (TO - S - 1) cyc();
    ack_n = 1'b0;
    repeat (S + 1) cyc();
    check("tmo_race_err", timeout_err, 0);
    check("tmo_race_obf", obf_n, 1);
    ack_n = 1'b1;
    repeat (5) cyc();
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      wr_en    = ($urandom % 8) == 0;
      din      = DW'($urandom);
      inte_set = ($urandom % 16) == 0;
      inte_clr = ($urandom % 24) == 0;
      if (($urandom % 200) == 0) mode1 = ~mode1;
      if (($urandom % 4) == 0) ack_n = ~ack_n;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
